cam_rgb332_packer: RTL and testbench

Source side of the RGB332 pixel format consumed by the pixel-difference logic. The block takes the camera's RGB565 byte stream (two bytes per pixel, high byte first, framed by `vsync`/`href`), assembles each pixel and quantizes it to one RGB332 byte (`{r[2:0], g[2:0], b[1:0]}`). It tags each output pixel with x/y coordinates and presents it on a valid/ready port to the frame buffer and the image-processing pipeline.

---
 rtl/cam_pkg.sv | 37 +++
 rtl/rgb565_to_rgb332.sv | 47 ++++
 rtl/cam_rgb332_packer.sv | 167 ++++++++++++++++
 tb/tb_cam_rgb332_packer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared camera/pixel definitions: packer FSM states, err_flags bit indices and
// RGB332 field positions (also consumed by the pixel-difference logic).
package cam_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_LINE  = 2'd1,
    BYTE_HI    = 2'd2,
    BYTE_LO    = 2'd3
  } cam_state_e;

  localparam int unsigned ERR_W         = 3;
  localparam int unsigned ERR_PARTIAL   = 0;
  localparam int unsigned ERR_OVERRUN   = 1;
  localparam int unsigned ERR_LINE_LONG = 2;

  localparam int unsigned PX_W      = 8;
  localparam int unsigned RGB_R_LSB = 5;
  localparam int unsigned RGB_R_W   = 3;
  localparam int unsigned RGB_G_LSB = 2;
  localparam int unsigned RGB_G_W   = 3;
  localparam int unsigned RGB_B_LSB = 0;
  localparam int unsigned RGB_B_W   = 2;

  // Place the three quantized fields at their RGB332 positions.
  function automatic logic [PX_W-1:0] rgb332_pack(input logic [RGB_R_W-1:0] r,
                                                  input logic [RGB_G_W-1:0] g,
                                                  input logic [RGB_B_W-1:0] b);
    logic [PX_W-1:0] px;
    px = '0;
    px[RGB_R_LSB +: RGB_R_W] = r;
    px[RGB_G_LSB +: RGB_G_W] = g;
    px[RGB_B_LSB +: RGB_B_W] = b;
    return px;
  endfunction

endpackage

// File: rtl/rgb565_to_rgb332.sv
// Combinational RGB565 -> RGB332 quantizer. CAM_ROUND_EN selects
// round-to-nearest with saturation; otherwise the fields are truncated.
module rgb565_to_rgb332
  import cam_pkg::*;
(
  input  logic [7:0]      i_hi,
  input  logic [7:0]      i_lo,
  output logic [PX_W-1:0] o_px_c
);

  logic [4:0]         w_r5;
  logic [5:0]         w_g6;
  logic [4:0]         w_b5;
  logic [RGB_R_W-1:0] w_r3;
  logic [RGB_G_W-1:0] w_g3;
  logic [RGB_B_W-1:0] w_b2;

  assign w_r5 = i_hi[7:3];
  assign w_g6 = {i_hi[2:0], i_lo[7:5]};
  assign w_b5 = i_lo[4:0];

`ifdef CAM_ROUND_EN
  logic [5:0] w_r_sum;
  logic [6:0] w_g_sum;
  logic [5:0] w_b_sum;
  logic [3:0] w_r_q;
  logic [3:0] w_g_q;
  logic [2:0] w_b_q;

  assign w_r_sum = 6'(w_r5) + 6'd2;
  assign w_g_sum = 7'(w_g6) + 7'd4;
  assign w_b_sum = 6'(w_b5) + 6'd4;
  assign w_r_q   = 4'(w_r_sum >> 2);
  assign w_g_q   = 4'(w_g_sum >> 3);
  assign w_b_q   = 3'(w_b_sum >> 3);
  assign w_r3    = (w_r_q > 4'd7) ? 3'd7 : w_r_q[2:0];
  assign w_g3    = (w_g_q > 4'd7) ? 3'd7 : w_g_q[2:0];
  assign w_b2    = (w_b_q > 3'd3) ? 2'd3 : w_b_q[1:0];
`else
  assign w_r3 = 3'(w_r5 >> 2);
  assign w_g3 = 3'(w_g6 >> 3);
  assign w_b2 = 2'(w_b5 >> 3);
`endif

  assign o_px_c = rgb332_pack(w_r3, w_g3, w_b2);

endmodule

// File: rtl/cam_rgb332_packer.sv
// Camera RGB565 byte stream -> RGB332 pixels tagged with (x,y) on a one-entry
// valid/ready output register. Quantizer rounding is selected by CAM_ROUND_EN.
module cam_rgb332_packer
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        vsync,
  input  logic                        href,
  input  logic                        in_valid,
  input  logic [7:0]                  in_byte,
  output logic                        px_valid,
  input  logic                        px_ready,
  output logic [PX_W-1:0]             px,
  output logic [$clog2(H_ACTIVE)-1:0] px_x,
  output logic [$clog2(V_ACTIVE)-1:0] px_y,
  output logic                        frame_done,
  output logic [ERR_W-1:0]            err_flags
);

  localparam int unsigned XW  = $clog2(H_ACTIVE);
  localparam int unsigned YW  = $clog2(V_ACTIVE);
  // Counters reach H_ACTIVE / V_ACTIVE, so they carry one extra value.
  localparam int unsigned XCW = $clog2(H_ACTIVE + 1);
  localparam int unsigned YCW = $clog2(V_ACTIVE + 1);

  cam_state_e       r_state;
  cam_state_e       w_state_nxt;
  logic             r_vsync;
  logic             r_href;
  logic [7:0]       r_hi;
  logic [XCW-1:0]   r_x;
  logic [YCW-1:0]   r_y;
  logic             r_px_valid;
  logic [PX_W-1:0]  r_px;
  logic [XW-1:0]    r_px_x;
  logic [YW-1:0]    r_px_y;
  logic             r_frame_done;
  logic [ERR_W-1:0] r_err;

  logic            w_vs_rise;
  logic            w_href_fall;
  logic            w_byte;
  logic            w_last_line;
  logic            w_in_range;
  logic            w_frame_start;
  logic            w_load_hi;
  logic            w_pix;
  logic            w_line_end;
  logic            w_partial;
  logic            w_load;
  logic [PX_W-1:0] w_px;

  assign w_vs_rise   = vsync & ~r_vsync;
  assign w_href_fall = r_href & ~href;
  assign w_byte      = in_valid & href;
  assign w_last_line = (r_y == YCW'(V_ACTIVE - 1));
  assign w_in_range  = (r_x < XCW'(H_ACTIVE));
  assign w_load      = w_pix & w_in_range;

  rgb565_to_rgb332 u_quant (
    .i_hi   (r_hi),
    .i_lo   (in_byte),
    .o_px_c (w_px)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_FRAME;
    else        r_state <= w_state_nxt;
  end

  // Next state plus per-cycle datapath strobes; vsync rise overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_load_hi     = 1'b0;
    w_pix         = 1'b0;
    w_line_end    = 1'b0;
    w_partial     = 1'b0;
    if (w_vs_rise) begin
      w_state_nxt   = WAIT_LINE;
      w_frame_start = 1'b1;
    end else begin
      case (r_state)
        WAIT_FRAME: w_state_nxt = WAIT_FRAME;
        WAIT_LINE: begin
          if (href) w_state_nxt = BYTE_HI;
        end
        BYTE_HI, BYTE_LO: begin
          if (w_href_fall) begin
            w_line_end  = 1'b1;
            w_partial   = (r_state == BYTE_LO);
            w_state_nxt = w_last_line ? WAIT_FRAME : WAIT_LINE;
          end else if (w_byte) begin
            if (r_state == BYTE_HI) begin
              w_load_hi   = 1'b1;
              w_state_nxt = BYTE_LO;
            end else begin
              w_pix       = 1'b1;
              w_state_nxt = BYTE_HI;
            end
          end
        end
        default: w_state_nxt = WAIT_FRAME;
      endcase
    end
  end

  // Sync edge detectors, counters, sticky errors and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_hi         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_px_valid   <= 1'b0;
      r_px         <= '0;
      r_px_x       <= '0;
      r_px_y       <= '0;
      r_frame_done <= 1'b0;
      r_err        <= '0;
    end else begin
      r_vsync      <= vsync;
      r_href       <= href;
      r_frame_done <= w_line_end & w_last_line;
      if (w_load_hi) r_hi <= in_byte;

      if (w_frame_start) begin
        r_x   <= '0;
        r_y   <= '0;
        r_err <= '0;
      end else begin
        if (w_line_end) begin
          r_x <= '0;
          r_y <= r_y + YCW'(1);
        end else if (w_load) begin
          r_x <= r_x + XCW'(1);
        end
        if (w_partial)                          r_err[ERR_PARTIAL]   <= 1'b1;
        if (w_pix && !w_in_range)               r_err[ERR_LINE_LONG] <= 1'b1;
        if (w_load && r_px_valid && !px_ready)  r_err[ERR_OVERRUN]   <= 1'b1;
      end

      // The camera cannot stall: a new pixel always replaces the held one.
      if (w_load) begin
        r_px_valid <= 1'b1;
        r_px       <= w_px;
        r_px_x     <= XW'(r_x);
        r_px_y     <= YW'(r_y);
      end else if (px_ready) begin
        r_px_valid <= 1'b0;
      end
    end
  end

  assign px_valid   = r_px_valid;
  assign px         = r_px;
  assign px_x       = r_px_x;
  assign px_y       = r_px_y;
  assign frame_done = r_frame_done;
  assign err_flags  = r_err;

endmodule

// File: tb/tb_cam_rgb332_packer.sv
// Randomized self-checking bench for cam_rgb332_packer (H_ACTIVE=4, V_ACTIVE=2)
// against an arithmetic RGB565->RGB332 model and a pixel scoreboard.
module tb_cam_rgb332_packer;

  localparam int unsigned H = 4;
  localparam int unsigned V = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       px_ready = 1'b1;
  logic       px_valid;
  logic [7:0] px;
  logic [1:0] px_x;
  logic [0:0] px_y;
  logic       frame_done;
  logic [2:0] err_flags;

  cam_rgb332_packer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .href       (href),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px         (px),
    .px_x       (px_x),
    .px_y       (px_y),
    .frame_done (frame_done),
    .err_flags  (err_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] px;
    int         x;
    int         y;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         fd_cnt = 0;
  bit         mon_en = 1'b0;
  logic [2:0] exp_err;

  logic [7:0] dir_hi [4] = '{8'hF8, 8'hFF, 8'h84, 8'h38};
  logic [7:0] dir_lo [4] = '{8'h00, 8'hFF, 8'h10, 8'h00};
`ifdef CAM_ROUND_EN
  logic [7:0] dir_px [4] = '{8'hE0, 8'hFF, 8'h92, 8'h40};
`else
  logic [7:0] dir_px [4] = '{8'hE0, 8'hFF, 8'h92, 8'h20};
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [7:0] ref_px(input logic [7:0] hi, input logic [7:0] lo);
    int r5, g6, b5, r3, g3, b2;
    r5 = int'(hi) / 8;
    g6 = (int'(hi) % 8) * 8 + int'(lo) / 32;
    b5 = int'(lo) % 32;
`ifdef CAM_ROUND_EN
    r3 = (r5 + 2) / 4; if (r3 > 7) r3 = 7;
    g3 = (g6 + 4) / 8; if (g3 > 7) g3 = 7;
    b2 = (b5 + 4) / 8; if (b2 > 3) b2 = 3;
`else
    r3 = r5 / 4;
    g3 = g6 / 8;
    b2 = b5 / 8;
`endif
    return 8'(r3 * 32 + g3 * 4 + b2);
  endfunction

  // Scoreboard: every accepted pixel must be the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (frame_done) fd_cnt++;
    if (mon_en && rst_n && px_valid && px_ready) begin
      if (q.size() == 0) begin
        check("px_unexpected", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("px", 32'(px), 32'(e.px));
        check("px_x", 32'(px_x), 32'(e.x));
        check("px_y", 32'(px_y), 32'(e.y));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_byte  = b;
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic run_line(input int npx, input bit half, input bit directed, input bit rnd, input int y);
    logic [7:0] hi, lo, want;
    href = 1'b1;
    tick();
    for (int i = 0; i < npx; i++) begin
      hi   = directed ? dir_hi[i] : 8'($urandom);
      lo   = directed ? dir_lo[i] : 8'($urandom);
      want = directed ? dir_px[i] : ref_px(hi, lo);
      if (i < int'(H)) q.push_back('{px: want, x: i, y: y});
      send_byte(hi, rnd ? int'($urandom_range(0, 2)) : 0);
      send_byte(lo, rnd ? int'($urandom_range(0, 2)) : 0);
    end
    if (npx > int'(H)) exp_err[2] = 1'b1;
    if (half) begin
      send_byte(8'($urandom), 0);
      exp_err[0] = 1'b1;
    end
    href = 1'b0;
    repeat (4) tick();
  endtask

  // mode 0: full 4-pixel lines, 1: random, 2: directed quantization line 0, 3: partial on line 0
  task automatic run_frame(input int mode);
    int fd0, npx;
    bit half;
    fd0     = fd_cnt;
    exp_err = 3'b000;
    vsync_pulse();
    for (int y = 0; y < int'(V); y++) begin
      npx  = (mode == 1) ? int'($urandom_range(1, 5)) : ((mode == 3 && y == 0) ? 2 : 4);
      half = (mode == 1) ? ($urandom_range(0, 3) == 0) : (mode == 3 && y == 0);
      run_line(npx, half, (mode == 2 && y == 0), (mode == 1), y);
    end
    repeat (3) tick();
    check("frame_done_cnt", 32'(fd_cnt - fd0), 32'd1);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("err_flags", 32'(err_flags), 32'(exp_err));
  endtask

  logic [7:0] a1, b1, a2, b2;

  initial begin
    #1;
    check("rst_px_valid", 32'(px_valid), 32'd0);
    check("rst_px", 32'(px), 32'd0);
    check("rst_px_x", 32'(px_x), 32'd0);
    check("rst_px_y", 32'(px_y), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err_flags", 32'(err_flags), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    mon_en   = 1'b1;
    px_ready = 1'b1;
    run_frame(2);
    run_frame(0);
    run_frame(3);
    repeat (6) run_frame(1);

    // Overrun: two pixels while px_ready is low.
    mon_en = 1'b0;
    q.delete();
    a1 = 8'($urandom); b1 = 8'($urandom);
    a2 = 8'($urandom); b2 = 8'($urandom);
    vsync_pulse();
    href = 1'b1;
    tick();
    px_ready = 1'b0;
    send_byte(a1, 0);
    check("lat_before_lo", 32'(px_valid), 32'd0);
    send_byte(b1, 0);
    check("lat_after_lo", 32'(px_valid), 32'd1);
    check("lat_px", 32'(px), 32'(ref_px(a1, b1)));
    send_byte(a2, 0);
    send_byte(b2, 0);
    check("ovr_px_valid", 32'(px_valid), 32'd1);
    check("ovr_px", 32'(px), 32'(ref_px(a2, b2)));
    check("ovr_px_x", 32'(px_x), 32'd1);
    check("ovr_err", 32'(err_flags), 32'b010);
    repeat (2) tick();
    check("ovr_hold", 32'(px_valid), 32'd1);
    px_ready = 1'b1;
    tick();
    check("ovr_drain", 32'(px_valid), 32'd0);
    href = 1'b0;
    repeat (2) tick();
    vsync_pulse();
    check("ovr_err_clear", 32'(err_flags), 32'd0);

    // Reset while in BYTE_LO with a held pixel.
    href = 1'b1;
    tick();
    px_ready = 1'b0;
    send_byte(8'h84, 0);
    send_byte(8'h10, 0);
    send_byte(8'hF8, 0);
    check("pre_rst_valid", 32'(px_valid), 32'd1);
    #2 rst_n = 1'b0;
    href = 1'b0;
    #1;
    check("arst_px_valid", 32'(px_valid), 32'd0);
    check("arst_px", 32'(px), 32'd0);
    check("arst_px_x", 32'(px_x), 32'd0);
    check("arst_px_y", 32'(px_y), 32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    check("arst_err_flags", 32'(err_flags), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    px_ready = 1'b1;
    mon_en   = 1'b1;
    run_frame(0);
    run_frame(1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
